// File: rtl/reg_file_sequencer.sv
// rtl/reg_file_sequencer.sv - register-file request sequencer with in-order write queue and read forwarding
module reg_file_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int WQ_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]       rd_addr1,
    input  logic [ADDR_WIDTH-1:0]       rd_addr2,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data1,
    output logic [DATA_WIDTH-1:0]       rd_data2,
    input  logic                        wr_req_valid,
    output logic                        wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        rf_reg_write,
    output logic [ADDR_WIDTH-1:0]       rf_read_reg1,
    output logic [ADDR_WIDTH-1:0]       rf_read_reg2,
    output logic [ADDR_WIDTH-1:0]       rf_write_reg,
    output logic [DATA_WIDTH-1:0]       rf_write_data,
    input  logic [DATA_WIDTH-1:0]       rf_read_data1,
    input  logic [DATA_WIDTH-1:0]       rf_read_data2,
    output logic [$clog2(WQ_DEPTH):0]   wq_count,
    output logic                        wq_empty
);

    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] q_addr [WQ_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [WQ_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  rd_accept;
    logic                  wr_accept;
    logic                  pop;

    logic                  fwd_hit1;
    logic                  fwd_hit2;
    logic [DATA_WIDTH-1:0] fwd_data1;
    logic [DATA_WIDTH-1:0] fwd_data2;
    logic [PTR_W-1:0]      fwd_idx;

    logic                  snap_hit1;
    logic                  snap_hit2;
    logic [DATA_WIDTH-1:0] snap_data1;
    logic [DATA_WIDTH-1:0] snap_data2;

    // Handshakes: a full queue blocks reads so IDLE is free to drain one entry.
    always_comb begin
        rd_req_ready = (state == IDLE) && (count != FULL_COUNT);
        wr_req_ready = (count < FULL_COUNT);
        rd_accept    = rd_req_valid && rd_req_ready;
        wr_accept    = wr_req_valid && wr_req_ready;
        pop          = (state == IDLE) && !rd_accept && (count != '0);
        wq_count     = count;
        wq_empty     = (count == '0);
    end

    // Forwarding search: walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        fwd_idx   = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (q_addr[fwd_idx] == rd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = q_data[fwd_idx];
                end
                if (q_addr[fwd_idx] == rd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = q_data[fwd_idx];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: a read walks IDLE -> RD_ISSUE -> RD_RESP -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (rd_accept) state_next = RD_ISSUE;
            RD_ISSUE: state_next = RD_RESP;
            RD_RESP:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Queue payload storage; contents are meaningful only below count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            q_addr[tail] <= wr_addr;
            q_data[tail] <= wr_data;
        end
    end

    // Queue pointers, register-file port, forward snapshots and read response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rf_reg_write  <= 1'b0;
            rf_read_reg1  <= '0;
            rf_read_reg2  <= '0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            snap_hit1     <= 1'b0;
            snap_hit2     <= 1'b0;
            snap_data1    <= '0;
            snap_data2    <= '0;
            rd_valid      <= 1'b0;
            rd_data1      <= '0;
            rd_data2      <= '0;
        end else begin
            rf_reg_write <= pop;
            rd_valid     <= (state == RD_RESP);

            if (rd_accept) begin
                rf_read_reg1 <= rd_addr1;
                rf_read_reg2 <= rd_addr2;
                snap_hit1    <= fwd_hit1;
                snap_hit2    <= fwd_hit2;
                snap_data1   <= fwd_data1;
                snap_data2   <= fwd_data2;
            end

            if (pop) begin
                rf_write_reg  <= q_addr[head];
                rf_write_data <= q_data[head];
                head          <= head + PTR_W'(1);
            end

            if (wr_accept) begin
                tail <= tail + PTR_W'(1);
            end

            case ({wr_accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (state == RD_RESP) begin
                rd_data1 <= snap_hit1 ? snap_data1 : rf_read_data1;
                rd_data2 <= snap_hit2 ? snap_data2 : rf_read_data2;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// tb/tb_reg_file_sequencer.sv - scoreboard testbench for reg_file_sequencer
module tb_reg_file_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int WD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          rd_valid;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          wr_req_valid;
    logic          wr_req_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rf_reg_write;
    logic [AW-1:0] rf_read_reg1;
    logic [AW-1:0] rf_read_reg2;
    logic [AW-1:0] rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_read_data1;
    logic [DW-1:0] rf_read_data2;
    logic [$clog2(WD):0] wq_count;
    logic          wq_empty;

    reg_file_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WQ_DEPTH(WD)) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .rd_valid      (rd_valid),
        .rd_data1      (rd_data1),
        .rd_data2      (rd_data2),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rf_reg_write  (rf_reg_write),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .wq_count      (wq_count),
        .wq_empty      (wq_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            cyc;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_exp_t;

    rd_exp_t       exp_rd [$];
    wr_exp_t       exp_wr [$];
    rd_exp_t       re;
    wr_exp_t       we;
    logic [DW-1:0] arch   [32];
    logic [DW-1:0] rf_mem [32];
    logic          rf_load;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            rdv_count = 0;
    int            r7_pulses = 0;

    // Register-file model: a write cycle suppresses that cycle's read capture.
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= (i < 3) ? DW'(3 - i) : '0;
        end else if (rf_reg_write) begin
            rf_mem[rf_write_reg] <= rf_write_data;
        end else begin
            rf_read_data1 <= rf_mem[rf_read_reg1];
            rf_read_data2 <= rf_mem[rf_read_reg2];
        end
    end

    // Edge counter used for read-latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: checks outputs, then predicts the handshakes of the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_rd.delete();
            exp_wr.delete();
            for (int i = 0; i < 32; i++) arch[i] = rf_mem[i];
        end else begin
            if (rd_valid) begin
                rdv_count++;
                n_checks++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: rd_valid=1 data1=%h, required no response", rd_data1);
                end else begin
                    re = exp_rd.pop_front();
                    if (rd_data1 !== re.d1 || rd_data2 !== re.d2 || cyc != re.cyc) begin
                        n_fail++;
                        $display("FAIL rd_resp: data1=%h data2=%h edge=%0d, required data1=%h data2=%h edge=%0d",
                                 rd_data1, rd_data2, cyc, re.d1, re.d2, re.cyc);
                    end
                end
            end
            if (rf_reg_write) begin
                if (rf_write_reg == AW'(7)) r7_pulses++;
                n_checks++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL rf_write_unexpected: reg=%0d data=%h, required no write", rf_write_reg, rf_write_data);
                end else begin
                    we = exp_wr.pop_front();
                    if (rf_write_reg !== we.a || rf_write_data !== we.d) begin
                        n_fail++;
                        $display("FAIL rf_write: reg=%0d data=%h, required reg=%0d data=%h",
                                 rf_write_reg, rf_write_data, we.a, we.d);
                    end
                end
            end
            n_checks++;
            if (int'(wq_count) > WD || wq_empty !== (wq_count == 0)) begin
                n_fail++;
                $display("FAIL wq_bounds: count=%0d empty=%b, required count<=%0d and empty==(count==0)",
                         wq_count, wq_empty, WD);
            end
            if (rd_req_valid && rd_req_ready) begin
                re.d1  = arch[rd_addr1];
                re.d2  = arch[rd_addr2];
                re.cyc = cyc + 3;
                exp_rd.push_back(re);
            end
            if (wr_req_valid && wr_req_ready) begin
                arch[wr_addr] = wr_data;
                we.a = wr_addr;
                we.d = wr_data;
                exp_wr.push_back(we);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bit to = 1'b1;
        rd_addr1 = a1;
        rd_addr2 = a2;
        rd_req_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rd_req_ready) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL rd_accept_timeout: rd_req_ready=0, required 1 within 50 cycles");
        end
        tick();
        rd_req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit to = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_req_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wr_req_ready) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL wr_accept_timeout: wr_req_ready=0, required 1 within 50 cycles");
        end
        tick();
        wr_req_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        bit to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_rd.size() == 0 && exp_wr.size() == 0 && wq_empty && !rf_reg_write) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL quiet_timeout: pending reads=%0d writes=%0d, required 0 within 100 cycles",
                     exp_rd.size(), exp_wr.size());
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rf_load = 1'b1;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        wr_addr = '0;
        wr_data = '0;
        tick();
        rf_load = 1'b0;
        tick();
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data1 !== '0 || rd_data2 !== '0) begin
            n_fail++;
            $display("FAIL reset_rd: valid=%b d1=%h d2=%h, required 0 0 0", rd_valid, rd_data1, rd_data2);
        end
        n_checks++;
        if (rf_reg_write !== 1'b0 || rf_read_reg1 !== '0 || rf_read_reg2 !== '0 ||
            rf_write_reg !== '0 || rf_write_data !== '0) begin
            n_fail++;
            $display("FAIL reset_rf: we=%b rr1=%0d rr2=%0d wr=%0d wd=%h, required all 0",
                     rf_reg_write, rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data);
        end
        n_checks++;
        if (wq_count !== '0 || wq_empty !== 1'b1 || rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_queue: count=%0d empty=%b rdy_r=%b rdy_w=%b, required 0 1 1 1",
                     wq_count, wq_empty, rd_req_ready, wr_req_ready);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        do_read(AW'(0), AW'(1));
        wait_quiet();
        n_checks++;
        if (rd_data1 !== 32'd3 || rd_data2 !== 32'd2) begin
            n_fail++;
            $display("FAIL basic_read: d1=%h d2=%h, required 3 2", rd_data1, rd_data2);
        end
    endtask

    task automatic test_forward();
        do_write(AW'(5), 32'hDEADBEEF);
        do_read(AW'(5), AW'(2));
        wait_quiet();
        n_checks++;
        if (rd_data1 !== 32'hDEADBEEF || rd_data2 !== 32'd1) begin
            n_fail++;
            $display("FAIL forward: d1=%h d2=%h, required deadbeef 1", rd_data1, rd_data2);
        end
        n_checks++;
        if (rf_mem[5] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL forward_commit: r5=%h, required deadbeef", rf_mem[5]);
        end
    endtask

    task automatic test_youngest();
        r7_pulses = 0;
        do_write(AW'(7), 32'd1);
        do_write(AW'(7), 32'd2);
        do_write(AW'(7), 32'd3);
        do_read(AW'(7), AW'(7));
        wait_quiet();
        n_checks++;
        if (rd_data1 !== 32'd3 || rd_data2 !== 32'd3) begin
            n_fail++;
            $display("FAIL youngest: d1=%h d2=%h, required 3 3", rd_data1, rd_data2);
        end
        n_checks++;
        if (rf_mem[7] !== 32'd3 || r7_pulses != 3) begin
            n_fail++;
            $display("FAIL youngest_commit: r7=%h pulses=%0d, required 3 3", rf_mem[7], r7_pulses);
        end
    endtask

    task automatic test_full();
        bit saw_full = 1'b0;
        bit to;
        rd_addr1 = AW'(10);
        rd_addr2 = AW'(11);
        rd_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_addr = AW'(10 + i);
            wr_data = DW'(32'hA0 + i);
            wr_req_valid = 1'b1;
            to = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (wq_count == 4) begin
                    saw_full = 1'b1;
                    n_checks++;
                    if (wr_req_ready !== 1'b0 || rd_req_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL full_ready: wr_rdy=%b rd_rdy=%b, required 0 0", wr_req_ready, rd_req_ready);
                    end
                end
                if (wr_req_ready) begin
                    to = 1'b0;
                    break;
                end
            end
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL full_write_timeout: write %0d not accepted, required accept within 40", i);
            end
            tick();
        end
        wr_req_valid = 1'b0;
        repeat (4) tick();
        rd_req_valid = 1'b0;
        n_checks++;
        if (!saw_full) begin
            n_fail++;
            $display("FAIL full_reached: max count below 4, required count to reach 4");
        end
        wait_quiet();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rf_mem[10 + i] !== DW'(32'hA0 + i)) begin
                n_fail++;
                $display("FAIL full_commit: r%0d=%h, required %h", 10 + i, rf_mem[10 + i], DW'(32'hA0 + i));
            end
        end
    endtask

    task automatic test_same_edge();
        bit to = 1'b1;
        rd_addr1 = AW'(9);
        rd_addr2 = AW'(9);
        wr_addr = AW'(9);
        wr_data = 32'h55;
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rd_req_ready && wr_req_ready) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL same_edge_timeout: ready not both high, required within 50");
        end
        tick();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        wait_quiet();
        n_checks++;
        if (rd_data1 !== 32'd0) begin
            n_fail++;
            $display("FAIL same_edge_old: d1=%h, required 0", rd_data1);
        end
        do_read(AW'(9), AW'(0));
        wait_quiet();
        n_checks++;
        if (rd_data1 !== 32'h55 || rd_data2 !== 32'd3) begin
            n_fail++;
            $display("FAIL same_edge_new: d1=%h d2=%h, required 55 3", rd_data1, rd_data2);
        end
    endtask

    task automatic test_reset_mid_read();
        int rdv_before;
        wr_addr = AW'(20);
        wr_data = 32'h1111;
        wr_req_valid = 1'b1;
        @(negedge clk);
        tick();
        wr_addr = AW'(21);
        wr_data = 32'h2222;
        rd_addr1 = AW'(3);
        rd_addr2 = AW'(4);
        rd_req_valid = 1'b1;
        @(negedge clk);
        tick();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        n_checks++;
        if (wq_count !== 3'd2) begin
            n_fail++;
            $display("FAIL mid_read_setup: count=%0d, required 2", wq_count);
        end
        rdv_before = rdv_count;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rf_reg_write !== 1'b0 || wq_count !== '0 || wq_empty !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_read_reset: we=%b count=%0d empty=%b rdv=%b, required 0 0 1 0",
                     rf_reg_write, wq_count, wq_empty, rd_valid);
        end
        tick();
        tick();
        reset = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (rdv_count != rdv_before) begin
            n_fail++;
            $display("FAIL mid_read_discard: rd_valid pulses=%0d, required 0", rdv_count - rdv_before);
        end
        n_checks++;
        if (rf_mem[20] !== 32'd0 || rf_mem[21] !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_read_drop: r20=%h r21=%h, required 0 0", rf_mem[20], rf_mem[21]);
        end
    endtask

    task automatic test_final_state();
        do_write(AW'(0), 32'h0BAD);
        do_read(AW'(0), AW'(5));
        wait_quiet();
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (rf_mem[i] !== arch[i]) begin
                n_fail++;
                $display("FAIL final_rf: r%0d=%h, required %h", i, rf_mem[i], arch[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_read();
        test_forward();
        test_youngest();
        test_full();
        test_same_edge();
        test_reset_mid_read();
        test_final_state();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
